pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/pll_lock_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, default
// timing constants and a small helper used to size the shared counter.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
  localparam int unsigned DEF_STABLE_CYCLES = 256;
  localparam int unsigned DEF_MAX_RETRY     = 3;

  // Largest of three durations; one counter serves every timed state.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous status inputs (lock, power-good,
// etc). Output trails the input by two clk edges; both stages clear on reset so
// a freshly reset consumer never sees a stale asserted status.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for lock with a
// bounded timeout and retry budget, requires a stable lock window before
// releasing downstream reset, and re-runs the sequence on loss of lock.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   HOLD       | PLL RESETB low for RST_CYCLES, downstream held in reset
//   WAIT_LOCK  | PLL running, waiting up to LOCK_TIMEOUT for synced lock
//   STABLE     | lock seen, counting STABLE_CYCLES consecutive locked cycles
//   RUN        | lock qualified, downstream released, ready high
//   FAIL       | retry budget spent, PLL parked in reset until relock_req
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Terminal counts: a state lasting N cycles exits when the counter shows N-1.
  localparam logic [CNT_W-1:0] RST_TC     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);

  logic             lock_s;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       retry_q, retry_d, retry_inc;
  logic             retry_exhausted;

  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic             fail_q, fail_d;

  // The raw LOCK pin is asynchronous to clk; only lock_s is used below.
  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Saturating increments so neither the counter nor the retry count can wrap.
  always_comb begin
    cnt_inc         = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    retry_inc       = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
    retry_exhausted = ({30'd0, retry_inc} >= MAX_RETRY);
  end

  // Next-state, counter and retry bookkeeping; relock_req overrides last.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q >= RST_TC) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT_TC) begin
          cnt_d   = '0;
          retry_d = retry_inc;
          state_d = retry_exhausted ? ST_FAIL : ST_HOLD;
        end
      end

      ST_STABLE: begin
        // A dropout is not a timeout: go back and wait again, budget untouched.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= STABLE_TC) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end

      ST_RUN: begin
        cnt_d   = '0;
        retry_d = '0;
        if (!lock_s) begin
          lock_lost_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end

      ST_FAIL: begin
        cnt_d = '0;
      end

      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Relock restarts from HOLD; a relock during HOLD would only extend it.
    // lock_lost keeps its value so a coincident lock drop in RUN still reports.
    if (relock_req && (state_q != ST_HOLD)) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                   (state_d == ST_RUN);
    sys_reset_d  = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  // State, counter and retry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Registered outputs; reset values put the PLL and downstream into reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_resetb = pll_resetb_q;
  assign sys_reset  = sys_reset_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: the stimulus process pushes every expected output change
// (value and clk-edge number); a monitor pops one entry per observed change.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic       fail;
  logic [1:0] retry_cnt;

  logic [6:0] obs;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [6:0] outs;
    int         cyc;
    string      name;
  } ev_t;

  ev_t exp_q[$];

  pll_lock_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_resetb (pll_resetb),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {pll_resetb, sys_reset, ready, lock_lost, fail, retry_cnt};

  function automatic logic [6:0] mk(input logic pr, input logic sr, input logic rdy,
                                    input logic ll, input logic fl, input logic [1:0] rc);
    return {pr, sr, rdy, ll, fl, rc};
  endfunction

  task automatic push(input logic [6:0] o, input int c, input string n);
    ev_t e;
    e.outs = o;
    e.cyc  = c;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of the output vector must match the next entry.
  initial begin
    logic [6:0] prev;
    ev_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (obs !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: outs=%b at cycle %0d, none expected", obs, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((obs !== e.outs) || (cyc != e.cyc)) begin
            errors++;
            $display("FAIL %s: got outs=%b at cycle %0d, expected outs=%b at cycle %0d",
                     e.name, obs, cyc, e.outs, e.cyc);
          end
        end
        prev = obs;
      end
    end
  end

  // Stimulus: outs = {pll_resetb, sys_reset, ready, lock_lost, fail, retry_cnt}.
  initial begin
    int r;
    int l;
    int m;
    int q;

    reset      = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    #1 reset   = 1'b1;
    push(mk(0, 1, 0, 0, 0, 2'd0), 1, "reset_state");
    repeat (3) @(negedge clk);

    // Normal lock: lock rises 100 cycles after PLL release.
    r = cyc;
    reset = 1'b0;
    push(mk(1, 1, 0, 0, 0, 2'd0), r + 16,  "a_pll_release");
    push(mk(1, 0, 1, 0, 0, 2'd0), r + 375, "a_run");
    wait_until(r + 116);
    pll_locked = 1'b1;
    wait_until(r + 420);

    // Loss of lock in RUN.
    l = cyc;
    pll_locked = 1'b0;
    push(mk(0, 1, 0, 1, 0, 2'd0), l + 3,  "d_lock_lost");
    push(mk(0, 1, 0, 0, 0, 2'd0), l + 4,  "d_pulse_end");
    push(mk(1, 1, 0, 0, 0, 2'd0), l + 19, "d_pll_release");

    // 3-cycle lock glitch at STABLE count 200 restarts the full window.
    m = l + 29;
    wait_until(m);
    pll_locked = 1'b1;
    push(mk(1, 0, 1, 0, 0, 2'd0), m + 465, "c_run_after_glitch");
    wait_until(m + 203);
    pll_locked = 1'b0;
    wait_until(m + 206);
    pll_locked = 1'b1;
    wait_until(m + 500);

    // Asynchronous reset mid-RUN: outputs change before the next clk edge.
    @(posedge clk);
    #2;
    reset = 1'b1;
    push(mk(0, 1, 0, 0, 0, 2'd0), cyc, "e_async_reset");
    wait_until(cyc + 3);
    r = cyc;
    reset = 1'b0;
    push(mk(1, 1, 0, 0, 0, 2'd0), r + 16,  "e_pll_release");
    push(mk(1, 0, 1, 0, 0, 2'd0), r + 273, "e_run");
    wait_until(r + 300);

    // Timeout and retry with lock held low.
    @(posedge clk);
    #2;
    reset = 1'b1;
    pll_locked = 1'b0;
    push(mk(0, 1, 0, 0, 0, 2'd0), cyc, "b_reset");
    wait_until(cyc + 3);
    r = cyc;
    reset = 1'b0;
    push(mk(1, 1, 0, 0, 0, 2'd0), r + 16,    "b_try1_release");
    push(mk(0, 1, 0, 0, 0, 2'd1), r + 4112,  "b_timeout1");
    push(mk(1, 1, 0, 0, 0, 2'd1), r + 4128,  "b_try2_release");
    push(mk(0, 1, 0, 0, 0, 2'd2), r + 8224,  "b_timeout2");
    push(mk(1, 1, 0, 0, 0, 2'd2), r + 8240,  "b_try3_release");
    push(mk(0, 1, 0, 0, 1, 2'd3), r + 12336, "b_fail");
    wait_until(r + 12536);

    // Relock from FAIL, then a normal lock.
    q = cyc;
    relock_req = 1'b1;
    push(mk(0, 1, 0, 0, 0, 2'd0), q + 1,   "f_relock");
    push(mk(1, 1, 0, 0, 0, 2'd0), q + 17,  "f_pll_release");
    push(mk(1, 0, 1, 0, 0, 2'd0), q + 376, "f_run");
    wait_until(q + 1);
    relock_req = 1'b0;
    wait_until(q + 117);
    pll_locked = 1'b1;
    wait_until(q + 420);

    // Lock drop and relock on the same edge in RUN, then relock during HOLD.
    l = cyc;
    pll_locked = 1'b0;
    push(mk(0, 1, 0, 1, 0, 2'd0), l + 3,  "g_lost_with_relock");
    push(mk(0, 1, 0, 0, 0, 2'd0), l + 4,  "g_pulse_end");
    push(mk(1, 1, 0, 0, 0, 2'd0), l + 19, "g_hold_ignores_relock");
    wait_until(l + 2);
    relock_req = 1'b1;
    wait_until(l + 3);
    relock_req = 1'b0;
    wait_until(l + 8);
    relock_req = 1'b1;
    wait_until(l + 9);
    relock_req = 1'b0;
    wait_until(l + 60);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected changes never seen, next is %s",
               exp_q.size(), exp_q[0].name);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
